pos_ring_target_filter: RTL

Sequential, table-driven successor to the single-cell position-ring hit check.
- Sits on each node of the inter-FPGA position ring.
- Compares every incoming position packet's global cell ID (GCID) against a runtime-loadable table of NUM_TARGETS target cells, each with per-axis wildcard masks.
- Copies hits into a local FWFT FIFO tagged with the matching entry index.
- Forwards packets to the next hop with a decremented hop count, or retires them at hop count 0.

---
 rtl/pos_ring_target_filter_pkg.sv | 28 ++
 rtl/pos_ring_target_filter_hit_fifo.sv | 60 ++++++
 rtl/pos_ring_target_filter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pos_ring_target_filter_pkg.sv
// Shared constants, target table entry type and match helper for the position-ring
// target filter.
package pos_ring_target_filter_pkg;

    localparam int unsigned GLOBAL_CELL_ID_WIDTH = 3;
    localparam int unsigned HOP_WIDTH            = 4;
    localparam int unsigned GCID_BITS            = 3 * GLOBAL_CELL_ID_WIDTH;

    typedef struct packed {
        logic                 en;
        logic [2:0]           mask;
        logic [GCID_BITS-1:0] gcid;
    } target_entry_t;

    // Axis a occupies gcid[a*W +: W] and is wildcarded by mask[a]; z is axis 0.
    function automatic logic entry_match(input target_entry_t e,
                                         input logic [GCID_BITS-1:0] g);
        logic ok;
        ok = e.en;
        for (int a = 0; a < 3; a++) begin
            ok = ok & (e.mask[a] |
                       (e.gcid[a*GLOBAL_CELL_ID_WIDTH +: GLOBAL_CELL_ID_WIDTH] ==
                        g[a*GLOBAL_CELL_ID_WIDTH +: GLOBAL_CELL_ID_WIDTH]));
        end
        return ok;
    endfunction

endpackage

// File: rtl/pos_ring_target_filter_hit_fifo.sv
// First-word fall-through FIFO holding local hits; pointers carry one extra wrap bit
// so full and empty can be told apart.
module pos_hit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             empty, do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid_o = !empty;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata_i;
            wptr_d                = wptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: empty pointers make stale words unobservable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pos_ring_target_filter.sv
// Ring node filter: matches packets against a loadable target table, copies hits to a
// local FIFO and forwards with decremented hop count or retires at hop 0.
module pos_ring_target_filter
    import pos_ring_target_filter_pkg::*;
#(
    parameter int unsigned GCID_W      = GLOBAL_CELL_ID_WIDTH,
    parameter int unsigned NUM_TARGETS = 4,
    parameter int unsigned IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    parameter int unsigned DATA_W      = 96,
    parameter int unsigned HOP_W       = HOP_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [3*GCID_W-1:0] cfg_gcid,
    input  logic [2:0]          cfg_mask,
    input  logic                cfg_en,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3*GCID_W-1:0] i_gcid,
    input  logic [HOP_W-1:0]    i_hops,
    input  logic [DATA_W-1:0]   i_data,
    output logic                o_ring_valid,
    input  logic                i_ring_ready,
    output logic [3*GCID_W-1:0] o_ring_gcid,
    output logic [HOP_W-1:0]    o_ring_hops,
    output logic [DATA_W-1:0]   o_ring_data,
    output logic                o_local_valid,
    input  logic                i_local_ready,
    output logic [3*GCID_W-1:0] o_local_gcid,
    output logic [DATA_W-1:0]   o_local_data,
    output logic [IDX_W-1:0]    o_local_idx,
    output logic [CNT_W-1:0]    o_hit_count,
    output logic [CNT_W-1:0]    o_retire_count
);

    localparam int unsigned FIFO_W = 3*GCID_W + DATA_W + IDX_W;

    target_entry_t       tbl_q [NUM_TARGETS];
    target_entry_t       tbl_d [NUM_TARGETS];
    logic                ring_valid_q, ring_valid_d;
    logic [3*GCID_W-1:0] ring_gcid_q, ring_gcid_d;
    logic [HOP_W-1:0]    ring_hops_q, ring_hops_d;
    logic [DATA_W-1:0]   ring_data_q, ring_data_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                fifo_full, ring_slot_free, xfer, retire;
    logic [FIFO_W-1:0]   fifo_rdata;

    assign ring_slot_free = !ring_valid_q || i_ring_ready;
    assign o_ready        = rst_n && ring_slot_free && !fifo_full;
    assign xfer           = i_valid && o_ready;
    assign retire         = xfer && (i_hops == '0);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_TARGETS - 1; k >= 0; k--) begin
            if (entry_match(tbl_q[k], i_gcid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we) begin
            for (int k = 0; k < NUM_TARGETS; k++) begin
                if (cfg_idx == IDX_W'(k)) begin
                    tbl_d[k] = '{en: cfg_en, mask: cfg_mask, gcid: cfg_gcid};
                end
            end
        end
    end

    always_comb begin
        ring_valid_d = ring_valid_q;
        ring_gcid_d  = ring_gcid_q;
        ring_hops_d  = ring_hops_q;
        ring_data_d  = ring_data_q;
        if (xfer && !retire) begin
            ring_valid_d = 1'b1;
            ring_gcid_d  = i_gcid;
            ring_hops_d  = i_hops - HOP_W'(1);
            ring_data_d  = i_data;
        end else if (i_ring_ready) begin
            ring_valid_d = 1'b0;
        end
    end

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (xfer && hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (retire && (ret_cnt_q != '1)) begin
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q        <= '{default: '0};
            ring_valid_q <= 1'b0;
            ring_gcid_q  <= '0;
            ring_hops_q  <= '0;
            ring_data_q  <= '0;
            hit_cnt_q    <= '0;
            ret_cnt_q    <= '0;
        end else begin
            tbl_q        <= tbl_d;
            ring_valid_q <= ring_valid_d;
            ring_gcid_q  <= ring_gcid_d;
            ring_hops_q  <= ring_hops_d;
            ring_data_q  <= ring_data_d;
            hit_cnt_q    <= hit_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    pos_hit_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (xfer && hit),
        .wdata_i ({i_gcid, i_data, hit_idx}),
        .full_o  (fifo_full),
        .pop_i   (i_local_ready),
        .valid_o (o_local_valid),
        .rdata_o (fifo_rdata)
    );

    assign {o_local_gcid, o_local_data, o_local_idx} = fifo_rdata;

    assign o_ring_valid   = ring_valid_q;
    assign o_ring_gcid    = ring_gcid_q;
    assign o_ring_hops    = ring_hops_q;
    assign o_ring_data    = ring_data_q;
    assign o_hit_count    = hit_cnt_q;
    assign o_retire_count = ret_cnt_q;

endmodule
